// File: rtl/pd_ctrl_pkg.sv
// Shared constants for the phase-detector lock sequencer.
// State encoding and default widths/counts.
package pd_ctrl_pkg;

  localparam int WIDTH_TMR_D = 21;
  localparam int WIDTH_ERR_D = 22;
  localparam int LOCK_CNT_D  = 8;
  localparam int MISS_CNT_D  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/pd_err_abs_cmp.sv
// Saturating |err| and the good/bad threshold compares.
// Purely combinational; both outputs are qualified by the sample strobe.
module pd_err_abs_cmp #(
  parameter int W = 22
) (
  input  logic         sample_i,
  input  logic [W-1:0] err_i,
  input  logic [W-2:0] lock_thresh_i,
  input  logic [W-2:0] unlock_thresh_i,
  output logic         good_o,
  output logic         bad_o
);

  logic [W-2:0] mag;

  // The most negative code has no positive twin, so it pins to max.
  always_comb begin
    mag = err_i[W-2:0];
    if (err_i[W-1]) begin
      if (err_i[W-2:0] == '0) mag = '1;
      else                    mag = ~err_i[W-2:0] + 1'b1;
    end
  end

  assign good_o = sample_i && (mag <= lock_thresh_i);
  assign bad_o  = sample_i && (mag > unlock_thresh_i);

endmodule

// File: rtl/pd_lock_ctrl.sv
// Lock-acquisition sequencer between phase detector and loop filter.
// Sets the detector window and gates error samples to the filter.
module pd_lock_ctrl
  import pd_ctrl_pkg::*;
#(
  parameter int WIDTH_TMR = WIDTH_TMR_D,
  parameter int WIDTH_ERR = WIDTH_ERR_D,
  parameter int LOCK_CNT  = LOCK_CNT_D,
  parameter int MISS_CNT  = MISS_CNT_D,
  parameter int WDOG_W    = 24,
  parameter logic [WDOG_W-1:0] WDOG_CYC = 24'd2500000
) (
  input  logic                 clk,
  input  logic                 sync_rst,
  input  logic                 enable,
  input  logic [WIDTH_TMR-1:0] period_len,
  input  logic [9:0]           win_wide,
  input  logic [9:0]           win_narrow,
  input  logic [WIDTH_ERR-2:0] lock_thresh,
  input  logic [WIDTH_ERR-2:0] unlock_thresh,
  input  logic                 sample_in,
  input  logic [WIDTH_ERR-1:0] err_in,
  input  logic                 pd_error_in,
  output logic [WIDTH_TMR-1:0] delay_len,
  output logic [9:0]           width_win,
  output logic [WIDTH_ERR-1:0] err_out,
  output logic                 err_valid,
  output logic                 loop_hold,
  output logic                 locked,
  output logic [1:0]           state_out,
  output logic [7:0]           lock_loss_cnt
);

  state_t state_q, state_d;

  logic [7:0] good_q, good_d;
  logic [7:0] bad_q, bad_d;
  logic [7:0] miss_q, miss_d;
  logic [7:0] loss_q, loss_d;

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic pd_err_q;

  logic [WIDTH_TMR-1:0] delay_q, delay_d;
  logic [WIDTH_TMR-1:0] half_w;
  logic [9:0]           width_q, width_d;
  logic [WIDTH_ERR-1:0] err_q;
  logic                 ev_q, ev_d;
  logic                 hold_q, hold_d;
  logic                 lock_q, lock_d;

  logic miss_ev, wdog_exp, acc;
  logic good_s, bad_s;

  pd_err_abs_cmp #(.W(WIDTH_ERR)) u_cmp (
    .sample_i        (sample_in),
    .err_i           (err_in),
    .lock_thresh_i   (lock_thresh),
    .unlock_thresh_i (unlock_thresh),
    .good_o          (good_s),
    .bad_o           (bad_s)
  );

  assign miss_ev  = pd_error_in && !pd_err_q;
  assign wdog_exp = (state_q != ST_IDLE) &&
                    (wdog_q == WDOG_CYC - 1'b1);
  // A sample only counts when nothing of higher priority lands with it.
  assign acc = enable && sample_in && !miss_ev && !wdog_exp;

  always_ff @(posedge clk) begin
    if (sync_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    miss_d  = miss_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ACQ;
        ST_ACQ: begin
          if (miss_ev) begin
            good_d = '0;
          end else if (acc) begin
            if (!good_s)
              good_d = '0;
            else if (good_q == 8'(LOCK_CNT - 1))
              state_d = ST_LOCK;
            else
              good_d = good_q + 8'd1;
          end
        end
        ST_LOCK: begin
          if (miss_ev || wdog_exp) begin
            state_d = ST_HOLD;
          end else if (acc) begin
            if (!bad_s)
              bad_d = '0;
            else if (bad_q == 8'(MISS_CNT - 1))
              state_d = ST_ACQ;
            else
              bad_d = bad_q + 8'd1;
          end
        end
        ST_HOLD: begin
          if (miss_ev) begin
            if (miss_q == 8'(MISS_CNT - 1))
              state_d = ST_ACQ;
            else
              miss_d = miss_q + 8'd1;
          end else if (wdog_exp) begin
            state_d = ST_ACQ;
          end else if (acc && good_s) begin
            state_d = ST_LOCK;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_d != state_q) begin
      good_d = '0;
      bad_d  = '0;
      miss_d = '0;
    end
  end

  always_comb begin
    wdog_d = wdog_q + 1'b1;
    if (state_q == ST_IDLE || !enable || sample_in || wdog_exp)
      wdog_d = '0;

    width_d = (state_d == ST_LOCK) ? win_narrow : win_wide;
    half_w  = WIDTH_TMR'(width_d[9:1]);
    delay_d = (period_len <= half_w) ? WIDTH_TMR'(1)
                                     : period_len - half_w;

    hold_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
    lock_d = (state_d == ST_LOCK);
    ev_d   = acc && (state_q == ST_ACQ || state_q == ST_LOCK);

    loss_d = loss_q;
    if (state_q == ST_LOCK && state_d != ST_LOCK && loss_q != 8'hFF)
      loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      good_q   <= '0;
      bad_q    <= '0;
      miss_q   <= '0;
      loss_q   <= '0;
      wdog_q   <= '0;
      pd_err_q <= 1'b0;
      delay_q  <= '0;
      width_q  <= '0;
      err_q    <= '0;
      ev_q     <= 1'b0;
      hold_q   <= 1'b1;
      lock_q   <= 1'b0;
    end else begin
      good_q   <= good_d;
      bad_q    <= bad_d;
      miss_q   <= miss_d;
      loss_q   <= loss_d;
      wdog_q   <= wdog_d;
      pd_err_q <= pd_error_in;
      delay_q  <= delay_d;
      width_q  <= width_d;
      ev_q     <= ev_d;
      hold_q   <= hold_d;
      lock_q   <= lock_d;
      if (ev_d) err_q <= err_in;
    end
  end

  assign delay_len     = delay_q;
  assign width_win     = width_q;
  assign err_out       = err_q;
  assign err_valid     = ev_q;
  assign loop_hold     = hold_q;
  assign locked        = lock_q;
  assign state_out     = state_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pd_lock_ctrl.sv
// Directed bench for pd_lock_ctrl with a shortened watchdog.
// Each task drives one scenario and checks inline.
module tb_pd_lock_ctrl;

  localparam int WD = 40;

  logic        clk = 1'b0;
  logic        sync_rst, enable;
  logic [20:0] period_len;
  logic [9:0]  win_wide, win_narrow;
  logic [20:0] lock_thresh, unlock_thresh;
  logic        sample_in, pd_error_in;
  logic [21:0] err_in;
  logic [20:0] delay_len;
  logic [9:0]  width_win;
  logic [21:0] err_out;
  logic        err_valid, loop_hold, locked;
  logic [1:0]  state_out;
  logic [7:0]  lock_loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pd_lock_ctrl #(.WDOG_CYC(24'(WD))) dut (
    .clk(clk), .sync_rst(sync_rst), .enable(enable),
    .period_len(period_len), .win_wide(win_wide),
    .win_narrow(win_narrow), .lock_thresh(lock_thresh),
    .unlock_thresh(unlock_thresh), .sample_in(sample_in),
    .err_in(err_in), .pd_error_in(pd_error_in),
    .delay_len(delay_len), .width_win(width_win),
    .err_out(err_out), .err_valid(err_valid),
    .loop_hold(loop_hold), .locked(locked),
    .state_out(state_out), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [21:0] e);
    sample_in = 1'b1;
    err_in    = e;
    tick();
    sample_in = 1'b0;
  endtask

  task automatic miss_edge;
    pd_error_in = 1'b1;
    tick();
    pd_error_in = 1'b0;
    tick();
  endtask

  task automatic relock(input string nm);
    for (int i = 0; i < 8; i++) begin
      pulse(22'd100);
      tick();
    end
    n_cmp++;
    if (state_out !== 2'd2) begin
      n_bad++;
      $display("FAIL %s got %0d want 2", nm, state_out);
    end
  endtask

  task automatic test_reset;
    sync_rst = 1'b1; enable = 1'b0;
    sample_in = 1'b0; pd_error_in = 1'b0; err_in = '0;
    period_len = 21'd1250000; win_wide = 10'd512;
    win_narrow = 10'd64;
    lock_thresh = 21'd200; unlock_thresh = 21'd4000;
    tick(); tick();
    n_cmp++;
    if ({state_out, delay_len, width_win, err_out, err_valid,
         loop_hold, locked, lock_loss_cnt} !==
        {2'd0, 21'd0, 10'd0, 22'd0, 1'b0, 1'b1, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_vals got st=%0d dl=%0d ww=%0d ev=%0d lh=%0d lk=%0d ll=%0d want 0/0/0/0/1/0/0",
               state_out, delay_len, width_win, err_valid,
               loop_hold, locked, lock_loss_cnt);
    end
    sync_rst = 1'b0; enable = 1'b1;
    tick();
    n_cmp++;
    if ({state_out, width_win, delay_len, loop_hold} !==
        {2'd1, 10'd512, 21'd1249744, 1'b0}) begin
      n_bad++;
      $display("FAIL acq_entry got st=%0d ww=%0d dl=%0d lh=%0d want 1/512/1249744/0",
               state_out, width_win, delay_len, loop_hold);
    end
  endtask

  task automatic test_acquire;
    for (int i = 0; i < 3; i++) begin
      pulse(22'd100);
      tick();
    end
    pulse(22'd300);
    n_cmp++;
    if (err_valid !== 1'b1 || err_out !== 22'd300) begin
      n_bad++;
      $display("FAIL acq_errpath got ev=%0d eo=%0d want 1/300",
               err_valid, err_out);
    end
    tick();
    n_cmp++;
    if (err_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL acq_evdrop got %0d want 0", err_valid);
    end
    for (int i = 0; i < 7; i++) begin
      pulse(22'd100);
      tick();
    end
    n_cmp++;
    if (state_out !== 2'd1 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL acq_seven got st=%0d lk=%0d want 1/0",
               state_out, locked);
    end
    pulse(22'd100);
    n_cmp++;
    if ({state_out, locked, width_win, delay_len, loop_hold,
         err_valid} !==
        {2'd2, 1'b1, 10'd64, 21'd1249968, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL acq_lock got st=%0d lk=%0d ww=%0d dl=%0d lh=%0d ev=%0d want 2/1/64/1249968/0/1",
               state_out, locked, width_win, delay_len, loop_hold,
               err_valid);
    end
    tick();
  endtask

  task automatic test_unlock;
    for (int i = 0; i < 3; i++) begin
      pulse(-22'sd5000);
      tick();
    end
    n_cmp++;
    if (state_out !== 2'd2 || err_out !== 22'h3FEC78) begin
      n_bad++;
      $display("FAIL unl_three got st=%0d eo=%0d want 2/-5000",
               state_out, $signed(err_out));
    end
    pulse(22'h200000);
    n_cmp++;
    if ({state_out, locked, lock_loss_cnt, width_win, err_valid,
         err_out} !==
        {2'd1, 1'b0, 8'd1, 10'd512, 1'b1, 22'h200000}) begin
      n_bad++;
      $display("FAIL unl_sat got st=%0d lk=%0d ll=%0d ww=%0d ev=%0d eo=%0h want 1/0/1/512/1/200000",
               state_out, locked, lock_loss_cnt, width_win,
               err_valid, err_out);
    end
    tick();
    relock("unl_relock");
  endtask

  task automatic test_holdover;
    pd_error_in = 1'b1;
    pulse(22'd100);
    n_cmp++;
    if ({state_out, err_valid, loop_hold, locked, lock_loss_cnt,
         width_win} !==
        {2'd3, 1'b0, 1'b1, 1'b0, 8'd2, 10'd512}) begin
      n_bad++;
      $display("FAIL hold_entry got st=%0d ev=%0d lh=%0d lk=%0d ll=%0d ww=%0d want 3/0/1/0/2/512",
               state_out, err_valid, loop_hold, locked,
               lock_loss_cnt, width_win);
    end
    tick();
    pd_error_in = 1'b0;
    tick();
    pulse(22'd100);
    n_cmp++;
    if (state_out !== 2'd2 || err_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_return got st=%0d ev=%0d want 2/0",
               state_out, err_valid);
    end
    tick();
    miss_edge();
    for (int i = 0; i < 3; i++) miss_edge();
    n_cmp++;
    if (state_out !== 2'd3 || lock_loss_cnt !== 8'd3) begin
      n_bad++;
      $display("FAIL hold_miss3 got st=%0d ll=%0d want 3/3",
               state_out, lock_loss_cnt);
    end
    miss_edge();
    n_cmp++;
    if (state_out !== 2'd1) begin
      n_bad++;
      $display("FAIL hold_miss4 got %0d want 1", state_out);
    end
    relock("hold_relock");
  endtask

  task automatic test_watchdog;
    int waited;
    miss_edge();
    period_len = 21'd100;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (state_out !== 2'd3 || lock_loss_cnt !== 8'd4) begin
      n_bad++;
      $display("FAIL wd_early got st=%0d ll=%0d want 3/4",
               state_out, lock_loss_cnt);
    end
    waited = 0;
    while (state_out !== 2'd1 && waited < WD + 10) begin
      tick();
      waited++;
    end
    n_cmp++;
    if ({state_out, width_win, delay_len, loop_hold} !==
        {2'd1, 10'd512, 21'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL wd_expire got st=%0d ww=%0d dl=%0d lh=%0d want 1/512/1/0",
               state_out, width_win, delay_len, loop_hold);
    end
    relock("wd_relock");
    n_cmp++;
    if (delay_len !== 21'd68) begin
      n_bad++;
      $display("FAIL wd_lockdelay got %0d want 68", delay_len);
    end
  endtask

  task automatic test_enable_reset;
    enable = 1'b0;
    tick();
    n_cmp++;
    if ({state_out, locked, loop_hold, lock_loss_cnt} !==
        {2'd0, 1'b0, 1'b1, 8'd5}) begin
      n_bad++;
      $display("FAIL en_drop got st=%0d lk=%0d lh=%0d ll=%0d want 0/0/1/5",
               state_out, locked, loop_hold, lock_loss_cnt);
    end
    enable = 1'b1;
    tick();
    relock("en_relock");
    miss_edge();
    sync_rst = 1'b1;
    tick();
    n_cmp++;
    if ({state_out, delay_len, width_win, err_out, err_valid,
         loop_hold, locked, lock_loss_cnt} !==
        {2'd0, 21'd0, 10'd0, 22'd0, 1'b0, 1'b1, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL mid_reset got st=%0d dl=%0d ww=%0d eo=%0d ev=%0d lh=%0d lk=%0d ll=%0d want all reset",
               state_out, delay_len, width_win, err_out, err_valid,
               loop_hold, locked, lock_loss_cnt);
    end
    sync_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_unlock();
    test_holdover();
    test_watchdog();
    test_enable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
